// File: rtl/calc_pkg.sv
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared key-code types, scanner state encoding and keypad layout.
// Revision : 1.0
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam int KEY_W = 5;
    localparam logic [KEY_W-1:0] KEY_NONE = 5'b11111;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        EMIT     = 3'd2,
        HOLD     = 3'd3,
        RELEASE  = 3'd4
    } scan_state_e;

    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_result_e;

    typedef struct packed {
        scan_result_e result;
        logic [3:0]   index;
    } scan_eval_t;

    // Key index = col*4 + row; the downstream register/ALU control decodes these.
    localparam logic [3:0] KEY_IDX_1   = 4'd0;
    localparam logic [3:0] KEY_IDX_4   = 4'd1;
    localparam logic [3:0] KEY_IDX_7   = 4'd2;
    localparam logic [3:0] KEY_IDX_CLR = 4'd3;
    localparam logic [3:0] KEY_IDX_2   = 4'd4;
    localparam logic [3:0] KEY_IDX_5   = 4'd5;
    localparam logic [3:0] KEY_IDX_8   = 4'd6;
    localparam logic [3:0] KEY_IDX_0   = 4'd7;
    localparam logic [3:0] KEY_IDX_3   = 4'd8;
    localparam logic [3:0] KEY_IDX_6   = 4'd9;
    localparam logic [3:0] KEY_IDX_9   = 4'd10;
    localparam logic [3:0] KEY_IDX_EQ  = 4'd11;
    localparam logic [3:0] KEY_IDX_ADD = 4'd12;
    localparam logic [3:0] KEY_IDX_SUB = 4'd13;
    localparam logic [3:0] KEY_IDX_MUL = 4'd14;
    localparam logic [3:0] KEY_IDX_DIV = 4'd15;

    function automatic scan_eval_t eval_snapshot(input logic [15:0] snap);
        scan_eval_t  r;
        int unsigned n;
        r.result = SCAN_NONE;
        r.index  = 4'd0;
        n        = 0;
        for (int i = 0; i < 16; i++) begin
            if (!snap[i]) begin
                n++;
                r.index = 4'(i);
            end
        end
        if (n == 1) begin
            r.result = SCAN_SINGLE;
        end else if (n > 1) begin
            r.result = SCAN_MULTI;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_row_sync.sv
// ============================================================================
// Module   : keypad_row_sync
// Purpose  : Two-flop synchronizer for the pulled-up keypad rows (idles high).
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 active-low keypad scan + debounce, one key code per press.
//            Define KEYPAD_REPEAT_EN to re-emit a held key every REPEAT_SCANS.
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]       w_row_sync;
    logic             w_tick;
    logic             w_scan_end;
    scan_eval_t       w_eval;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic [15:0]      snap_q, snap_d;
    scan_state_e      state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
    logic [KEY_W-1:0] key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    keypad_row_sync #(.WIDTH(4)) u_row_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (row),
        .sync_o  (w_row_sync)
    );

    assign w_tick     = (div_q == DIV_W'(SCAN_DIV - 1));
    assign w_scan_end = w_tick && (col_idx_q == 2'd3);

    always_comb begin
        div_d     = w_tick ? '0 : div_q + DIV_W'(1);
        col_idx_d = w_tick ? col_idx_q + 2'd1 : col_idx_q;
        col_d     = ~(4'b0001 << col_idx_d);
        snap_d    = snap_q;
        if (w_tick) begin
            snap_d[{col_idx_q, 2'b00} +: 4] = w_row_sync;
        end
    end

    // Evaluate including the column captured on this same tick.
    assign w_eval = eval_snapshot(snap_d);

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_SCANS + 1);
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    logic [31:0] unused_repeat_scans;
    assign unused_repeat_scans = REPEAT_SCANS;
`endif

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        stable_cnt_d = stable_cnt_q;
        rel_cnt_d    = rel_cnt_q;
`ifdef KEYPAD_REPEAT_EN
        rpt_cnt_d    = rpt_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (w_scan_end && (w_eval.result == SCAN_SINGLE)) begin
                    cand_d       = w_eval.index;
                    stable_cnt_d = CNT_W'(1);
                    state_d      = (DEBOUNCE_SCANS == 1) ? EMIT : DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (w_scan_end) begin
                    if ((w_eval.result == SCAN_SINGLE) && (w_eval.index == cand_q)) begin
                        stable_cnt_d = stable_cnt_q + CNT_W'(1);
                        if (stable_cnt_d == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_d = EMIT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            EMIT: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (w_scan_end) begin
                    if (w_eval.result == SCAN_NONE) begin
                        rel_cnt_d = CNT_W'(1);
                        state_d   = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if ((w_eval.result == SCAN_SINGLE) && (w_eval.index == cand_q)) begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                        if (rpt_cnt_d == RPT_W'(REPEAT_SCANS)) begin
                            state_d   = EMIT;
                            rpt_cnt_d = '0;
                        end
                    end else begin
                        rpt_cnt_d = '0;
                    end
`endif
                end
            end
            RELEASE: begin
                if (w_scan_end) begin
                    if (w_eval.result == SCAN_NONE) begin
                        rel_cnt_d = rel_cnt_q + CNT_W'(1);
                        if (rel_cnt_d == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they align with state_q.
    always_comb begin
        key_valid_d = (state_d == EMIT);
        key_code_d  = key_valid_d ? {1'b0, cand_d} : KEY_NONE;
        key_held_d  = (state_d == HOLD) || (state_d == RELEASE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q        <= '0;
            col_idx_q    <= 2'd0;
            col_q        <= 4'b1110;
            snap_q       <= '1;
            state_q      <= IDLE;
            cand_q       <= 4'd0;
            stable_cnt_q <= '0;
            rel_cnt_q    <= '0;
            key_code_q   <= KEY_NONE;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            div_q        <= div_d;
            col_idx_q    <= col_idx_d;
            col_q        <= col_d;
            snap_q       <= snap_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            stable_cnt_q <= stable_cnt_d;
            rel_cnt_q    <= rel_cnt_d;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Directed self-checking bench for keypad_scanner with a keypad model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scanner;
    import calc_pkg::*;

`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_HOLD100   = 2;
    localparam int EXP_HOLD200   = 4;
`else
    localparam int EXP_HOLD100   = 1;
    localparam int EXP_HOLD200   = 1;
`endif

    logic             clock;
    logic             reset;
    logic [3:0]       row;
    logic [3:0]       col;
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_held;

    logic [15:0]      pressed;
    logic [3:0]       exp_idx;
    logic [3:0]       exp_col;
    int               total;
    int               bad;
    int               cyc;
    int               pulses;
    int               first_pulse;
    int               last_pulse;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .REPEAT_SCANS   (3)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Keypad model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[c*4 + r] && (col[c] == 1'b0)) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cyc         = 0;
        pulses      = 0;
        first_pulse = -1;
        last_pulse  = -1;
        check("rst_col",   32'(col),       32'h0000000E);
        check("rst_code",  32'(key_code),  32'(KEY_NONE));
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_held",  32'(key_held),  32'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            cyc++;
            exp_col = 4'b0001 << ((cyc / 4) % 4);
            exp_col = ~exp_col;
            check("col_rotation", 32'(col), 32'(exp_col));
            if (key_valid === 1'b1) begin
                pulses++;
                check("pulse_code", 32'(key_code), 32'({1'b0, exp_idx}));
                if (first_pulse < 0) first_pulse = cyc;
`ifdef KEYPAD_REPEAT_EN
                if (last_pulse >= 0) check("repeat_gap", 32'(cyc - last_pulse), 32'd48);
`endif
                last_pulse = cyc;
            end else begin
                check("idle_code", 32'(key_code), 32'(KEY_NONE));
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        pressed     = '0;
        exp_idx     = 4'd0;
        exp_col     = 4'hF;
        total       = 0;
        bad         = 0;
        cyc         = 0;
        pulses      = 0;
        first_pulse = -1;
        last_pulse  = -1;

        // Idle keypad: no emission, columns rotate.
        do_reset();
        run(200);
        check("idle_pulses", 32'(pulses), 32'd0);

        // Key (col 2, row 1) held 100 cycles.
        do_reset();
        exp_idx    = 4'd9;
        pressed[9] = 1'b1;
        run(100);
        check("hold_pulses",  32'(pulses), 32'(EXP_HOLD100));
        check("hold_latency", 32'(first_pulse > 0 && first_pulse <= 51), 32'd1);
        check("held_pressed", 32'(key_held), 32'd1);
        pressed = '0;
        run(16);
        check("held_after_release", 32'(key_held), 32'd1);
        run(24);
        check("held_cleared",    32'(key_held), 32'd0);
        check("release_pulses",  32'(pulses),   32'(EXP_HOLD100));

        // Bounce: one scan pressed, one scan released, three times.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            pressed[9] = 1'b1;
            run(16);
            pressed[9] = 1'b0;
            run(16);
        end
        run(48);
        check("bounce_pulses", 32'(pulses),   32'd0);
        check("bounce_held",   32'(key_held), 32'd0);

        // Two keys together, then a held key disturbed by a second key.
        do_reset();
        pressed[0] = 1'b1;
        pressed[5] = 1'b1;
        run(100);
        check("multi_pulses", 32'(pulses), 32'd0);
        pressed = '0;
        run(40);
        exp_idx    = 4'd3;
        pressed[3] = 1'b1;
        run(40);
        check("idx3_first", 32'(pulses), 32'd1);
        pressed[5] = 1'b1;
        run(40);
        pressed[5] = 1'b0;
        run(40);
        check("idx3_no_second", 32'(pulses),   32'd1);
        check("idx3_held",      32'(key_held), 32'd1);
        pressed = '0;
        run(50);
        check("idx3_released",  32'(key_held), 32'd0);

        // Reset while key 7 is being debounced.
        do_reset();
        exp_idx    = 4'd7;
        pressed[7] = 1'b1;
        run(20);
        check("debounce_no_pulse", 32'(pulses), 32'd0);
        do_reset();
        run(60);
        check("post_reset_pulses",  32'(pulses), 32'd1);
        check("post_reset_latency", 32'(first_pulse > 0 && first_pulse <= 51), 32'd1);
        pressed = '0;
        run(50);

        // Key 12 held 200 cycles: auto-repeat only when enabled.
        do_reset();
        exp_idx     = 4'd12;
        pressed[12] = 1'b1;
        run(200);
        check("repeat_pulses", 32'(pulses), 32'(EXP_HOLD200));
        pressed = '0;
        run(60);
        check("repeat_after_release", 32'(pulses),   32'(EXP_HOLD200));
        check("repeat_held_cleared",  32'(key_held), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
